// File: rtl/cache_trace_seq.sv
// Trace-driven cache request sequencer: replays programmed read/write
// entries over a valid/ack port and tallies issues, stalls and data errors.
module cache_trace_seq #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int CNT_WIDTH = 16,
  localparam int IW = $clog2(DEPTH),
  localparam int EW = 3 + ADDR_WIDTH + DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  prog_we,
  input  logic [IW-1:0]         prog_idx,
  input  logic [EW-1:0]         prog_entry,
  input  logic                  start,
  input  logic                  loop,
  input  logic                  abort,
  output logic                  cache_req,
  output logic                  cache_we,
  output logic [ADDR_WIDTH-1:0] cache_addr,
  output logic [DATA_WIDTH-1:0] cache_wdata,
  input  logic                  cache_ack,
  input  logic [DATA_WIDTH-1:0] cache_rdata,
  output logic                  busy,
  output logic                  done,
  output logic [IW-1:0]         cur_idx,
  output logic [CNT_WIDTH-1:0]  issued_cnt,
  output logic [CNT_WIDTH-1:0]  stall_cnt,
  output logic [CNT_WIDTH-1:0]  err_cnt,
  output logic [IW-1:0]         first_err_idx,
  output logic                  err_flag
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    ISSUE,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] ent_q;

  logic                  ent_v;
  logic                  ent_we;
  logic                  ent_chk;
  logic [ADDR_WIDTH-1:0] ent_a;
  logic [DATA_WIDTH-1:0] ent_d;

  logic idle_like;
  logic go;
  logic last;
  logic mism;

  assign ent_v   = ent_q[EW-1];
  assign ent_we  = ent_q[EW-2];
  assign ent_chk = ent_q[EW-3];
  assign ent_a   = ent_q[DATA_WIDTH +: ADDR_WIDTH];
  assign ent_d   = ent_q[DATA_WIDTH-1:0];

  assign idle_like = (state_q == IDLE) || (state_q == DONE);
  assign go        = idle_like && start && !abort;
  assign last      = (cur_idx == IW'(DEPTH - 1));
  assign mism      = !ent_we && ent_chk && (cache_rdata != ent_d);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(
    input logic [CNT_WIDTH-1:0] v
  );
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE, DONE: if (start) state_d = FETCH;
        FETCH:      state_d = ISSUE;
        ISSUE: begin
          if (!ent_v)
            state_d = loop ? FETCH : DONE;
          else if (cache_ack)
            state_d = (!last || loop) ? FETCH : DONE;
        end
        default:    state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cache_req = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      FETCH: busy = 1'b1;
      ISSUE: begin
        busy      = 1'b1;
        cache_req = ent_v;
      end
      DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign cache_we    = cache_req & ent_we;
  assign cache_addr  = cache_req ? ent_a : '0;
  assign cache_wdata = cache_req ? ent_d : '0;

  // Trace memory deliberately survives reset.
  always_ff @(posedge clk) begin
    if (prog_we && idle_like) mem[prog_idx] <= prog_entry;
  end

  // Abort freezes all bookkeeping on its edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      ent_q         <= '0;
      cur_idx       <= '0;
      issued_cnt    <= '0;
      stall_cnt     <= '0;
      err_cnt       <= '0;
      first_err_idx <= '0;
      err_flag      <= 1'b0;
    end else if (!abort) begin
      if (go) begin
        cur_idx       <= '0;
        issued_cnt    <= '0;
        stall_cnt     <= '0;
        err_cnt       <= '0;
        first_err_idx <= '0;
        err_flag      <= 1'b0;
      end
      if (state_q == FETCH) ent_q <= mem[cur_idx];
      if (state_q == ISSUE) begin
        if (!ent_v) begin
          if (loop) cur_idx <= '0;
        end else if (cache_ack) begin
          issued_cnt <= sat_inc(issued_cnt);
          if (mism) begin
            err_cnt  <= sat_inc(err_cnt);
            err_flag <= 1'b1;
            if (!err_flag) first_err_idx <= cur_idx;
          end
          if (!last)     cur_idx <= cur_idx + IW'(1);
          else if (loop) cur_idx <= '0;
        end else begin
          stall_cnt <= sat_inc(stall_cnt);
        end
      end
    end
  end

endmodule
